// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: default sizes and the
// payload that is broadcast on the CDB.
package cdb_arbiter_pkg;

   localparam int CDB_N_REQ = 4;   // default number of functional-unit requesters
   localparam int CDB_TAG_W = 5;   // ROB tag width

   // One CDB broadcast. Tags wider than CDB_TAG_W are not supported.
   typedef struct packed {
      logic [CDB_TAG_W-1:0] tag;
      logic [31:0]          data;
      logic                 branch;
      logic                 branch_taken;
   } cdb_payload_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational one-hot select. The request vector is rotated right
// by the pointer so the pointer position becomes bit 0, the lowest set bit is
// chosen, and the one-hot result is rotated back left by the same amount.
// A pointer of zero degenerates to fixed lowest-index-first priority.
module rr_pick #(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] gnt_dbl;
   logic [N-1:0]   req_rot;
   logic [N-1:0]   gnt_rot;

   // Rotate requests so the search always starts at bit 0.
   always_comb begin
      req_dbl = {req, req} >> ptr;
      req_rot = req_dbl[N-1:0];
   end

   // Lowest-set-bit select on the rotated vector, then undo the rotation.
   always_comb begin
      gnt_rot = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (req_rot[j]) gnt_rot = N'(1) << j;
      end
      gnt_dbl = {gnt_rot, gnt_rot} << ptr;
      grant   = gnt_dbl[2*N-1:N];
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants the common data bus to one functional unit per cycle
// and registers the winning payload onto the Cdb_* outputs (latency 1).
// Build option: define CDB_ARB_RR_EN for round-robin arbitration with a
// priority pointer; otherwise lowest index wins and no pointer is kept.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int N_REQ = CDB_N_REQ,
   parameter int TAG_W = CDB_TAG_W
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       Fu_req,
   input  logic [N_REQ*TAG_W-1:0] Fu_tag,
   input  logic [N_REQ*32-1:0]    Fu_data,
   input  logic [N_REQ-1:0]       Fu_branch,
   input  logic [N_REQ-1:0]       Fu_branch_taken,
   input  logic                   flush,
   output logic [N_REQ-1:0]       Fu_grant,
   output logic                   Cdb_valid,
   output logic [TAG_W-1:0]       Cdb_rd_tag,
   output logic [31:0]            Cdb_data,
   output logic                   Cdb_branch,
   output logic                   Cdb_branch_taken
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]    ptr;
   logic [N_REQ-1:0] pick;
   logic             any_grant;
   cdb_payload_t     sel;
   cdb_payload_t     cdb_q;

   rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
      .req   (Fu_req),
      .ptr   (ptr),
      .grant (pick)
   );

   // No grant is issued while the pipeline is flushing or held in reset.
   always_comb begin
      Fu_grant  = (reset || flush) ? '0 : pick;
      any_grant = |Fu_grant;
   end

   // Select the granted requester's payload; a taken flag only counts on a branch.
   always_comb begin
      sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (Fu_grant[i]) begin
            sel.tag          = CDB_TAG_W'(Fu_tag[i*TAG_W +: TAG_W]);
            sel.data         = Fu_data[i*32 +: 32];
            sel.branch       = Fu_branch[i];
            sel.branch_taken = Fu_branch[i] & Fu_branch_taken[i];
         end
      end
   end

`ifdef CDB_ARB_RR_EN
   logic [PW-1:0] gnt_idx;
   logic [PW-1:0] next_ptr;

   // Encode the winner and point just past it, wrapping at N_REQ-1.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (Fu_grant[i]) gnt_idx = PW'(i);
      end
      next_ptr = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   end

   // Priority pointer: cleared by flush, advanced only on a grant.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)          ptr <= '0;
      else if (flush)     ptr <= '0;
      else if (any_grant) ptr <= next_ptr;
   end
`else
   assign ptr = '0;
`endif

   // Broadcast register: valid follows the grant, payload holds when idle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         Cdb_valid <= 1'b0;
         cdb_q     <= '0;
      end else begin
         Cdb_valid <= any_grant;
         if (any_grant) cdb_q <= sel;
      end
   end

   assign Cdb_rd_tag       = TAG_W'(cdb_q.tag);
   assign Cdb_data         = cdb_q.data;
   assign Cdb_branch       = cdb_q.branch;
   // A stale taken flag must not be seen on an idle bus.
   assign Cdb_branch_taken = cdb_q.branch_taken & cdb_q.branch & Cdb_valid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter. Expected grants follow the build: the
// round-robin table applies when CDB_ARB_RR_EN is defined, fixed priority
// otherwise.
module tb_cdb_arbiter;

   localparam int N_REQ = 4;
   localparam int TAG_W = 5;

   logic                   clock;
   logic                   reset;
   logic [N_REQ-1:0]       Fu_req;
   logic [N_REQ*TAG_W-1:0] Fu_tag;
   logic [N_REQ*32-1:0]    Fu_data;
   logic [N_REQ-1:0]       Fu_branch;
   logic [N_REQ-1:0]       Fu_branch_taken;
   logic                   flush;
   logic [N_REQ-1:0]       Fu_grant;
   logic                   Cdb_valid;
   logic [TAG_W-1:0]       Cdb_rd_tag;
   logic [31:0]            Cdb_data;
   logic                   Cdb_branch;
   logic                   Cdb_branch_taken;

   int n_checks;
   int n_fail;

   cdb_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
      .clock            (clock),
      .reset            (reset),
      .Fu_req           (Fu_req),
      .Fu_tag           (Fu_tag),
      .Fu_data          (Fu_data),
      .Fu_branch        (Fu_branch),
      .Fu_branch_taken  (Fu_branch_taken),
      .flush            (flush),
      .Fu_grant         (Fu_grant),
      .Cdb_valid        (Cdb_valid),
      .Cdb_rd_tag       (Cdb_rd_tag),
      .Cdb_data         (Cdb_data),
      .Cdb_branch       (Cdb_branch),
      .Cdb_branch_taken (Cdb_branch_taken)
   );

   // Clock: 10 time-unit period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Watchdog so the run always ends.
   initial begin
      #20000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      Fu_req          = '0;
      Fu_tag          = '0;
      Fu_data         = '0;
      Fu_branch       = '0;
      Fu_branch_taken = '0;
      flush           = 1'b0;
   endtask

   task automatic set_req(input int idx, input logic [TAG_W-1:0] tag,
                          input logic [31:0] data, input logic br, input logic tk);
      Fu_req[idx]                = 1'b1;
      Fu_tag[idx*TAG_W +: TAG_W] = tag;
      Fu_data[idx*32 +: 32]      = data;
      Fu_branch[idx]             = br;
      Fu_branch_taken[idx]       = tk;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      Fu_req = 4'b1111;
      #1;
      n_checks++;
      if (Fu_grant !== 4'b0000) begin
         n_fail++; $display("FAIL reset_grant: got %b want 0000", Fu_grant);
      end
      step();
      n_checks++;
      if ({Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken} !== '0) begin
         n_fail++; $display("FAIL reset_cdb: got v=%b tag=%0d data=%h br=%b tk=%b want all 0",
                            Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken);
      end
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      set_req(0, 5'd3, 32'h0000_00AA, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (Fu_grant !== 4'b0001) begin
         n_fail++; $display("FAIL single_grant: got %b want 0001", Fu_grant);
      end
      step();
      clear_inputs();
      n_checks++;
      if (Cdb_valid !== 1'b1 || Cdb_rd_tag !== 5'd3 || Cdb_data !== 32'h0000_00AA) begin
         n_fail++; $display("FAIL single_cdb: got v=%b tag=%0d data=%h want v=1 tag=3 data=000000aa",
                            Cdb_valid, Cdb_rd_tag, Cdb_data);
      end
      step();
      n_checks++;
      if (Cdb_valid !== 1'b0 || Cdb_rd_tag !== 5'd3 || Cdb_data !== 32'h0000_00AA) begin
         n_fail++; $display("FAIL idle_hold: got v=%b tag=%0d data=%h want v=0 tag=3 data=000000aa",
                            Cdb_valid, Cdb_rd_tag, Cdb_data);
      end
   endtask

   task automatic test_round_robin();
      logic [N_REQ-1:0] exp_g[5];
      logic [TAG_W-1:0] exp_t[5];
`ifdef CDB_ARB_RR_EN
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_t = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
`else
      exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
      exp_t = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
`endif
      do_reset();
      for (int i = 0; i < N_REQ; i++)
         set_req(i, TAG_W'(i + 1), 32'h100 + i, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         #1;
         n_checks++;
         if (Fu_grant !== exp_g[c]) begin
            n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", c, Fu_grant, exp_g[c]);
         end
         step();
         n_checks++;
         if (Cdb_valid !== 1'b1 || Cdb_rd_tag !== exp_t[c]) begin
            n_fail++; $display("FAIL rr_cdb[%0d]: got v=%b tag=%0d want v=1 tag=%0d",
                               c, Cdb_valid, Cdb_rd_tag, exp_t[c]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_wrap();
      logic [N_REQ-1:0] exp_a, exp_b;
`ifdef CDB_ARB_RR_EN
      exp_a = 4'b1000; exp_b = 4'b0001;
`else
      exp_a = 4'b0001; exp_b = 4'b0001;
`endif
      do_reset();
      // Grant requester 2 so the pointer moves to 3.
      set_req(2, 5'd2, 32'h22, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (Fu_grant !== 4'b0100) begin
         n_fail++; $display("FAIL wrap_setup: got %b want 0100", Fu_grant);
      end
      step();
      clear_inputs();
      set_req(0, 5'd10, 32'h10, 1'b0, 1'b0);
      set_req(3, 5'd13, 32'h13, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (Fu_grant !== exp_a) begin
         n_fail++; $display("FAIL wrap_first: got %b want %b", Fu_grant, exp_a);
      end
      step();
      #1;
      n_checks++;
      if (Fu_grant !== exp_b) begin
         n_fail++; $display("FAIL wrap_second: got %b want %b", Fu_grant, exp_b);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_flush();
      // Grant requester 1 (pointer would move to 2 in round-robin).
      set_req(1, 5'd5, 32'h55, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (Fu_grant !== 4'b0010) begin
         n_fail++; $display("FAIL flush_setup: got %b want 0010", Fu_grant);
      end
      step();
      clear_inputs();
      set_req(1, 5'd6, 32'h66, 1'b0, 1'b0);
      set_req(2, 5'd7, 32'h77, 1'b0, 1'b0);
      flush = 1'b1;
      #1;
      n_checks++;
      if (Fu_grant !== 4'b0000) begin
         n_fail++; $display("FAIL flush_grant: got %b want 0000", Fu_grant);
      end
      n_checks++;
      if (Cdb_valid !== 1'b1 || Cdb_rd_tag !== 5'd5) begin
         n_fail++; $display("FAIL flush_prior_bcast: got v=%b tag=%0d want v=1 tag=5", Cdb_valid, Cdb_rd_tag);
      end
      step();
      flush = 1'b0;
      n_checks++;
      if (Cdb_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_valid: got %b want 0", Cdb_valid);
      end
      #1;
      n_checks++;
      if (Fu_grant !== 4'b0010) begin
         n_fail++; $display("FAIL flush_after: got %b want 0010", Fu_grant);
      end
      step();
      clear_inputs();
   endtask

   task automatic test_branch();
      set_req(2, 5'd7, 32'hB0B0_0002, 1'b1, 1'b1);
      #1;
      n_checks++;
      if (Fu_grant !== 4'b0100) begin
         n_fail++; $display("FAIL branch_grant: got %b want 0100", Fu_grant);
      end
      step();
      clear_inputs();
      n_checks++;
      if (Cdb_valid !== 1'b1 || Cdb_branch !== 1'b1 || Cdb_branch_taken !== 1'b1 || Cdb_rd_tag !== 5'd7) begin
         n_fail++; $display("FAIL branch_cdb: got v=%b br=%b tk=%b tag=%0d want v=1 br=1 tk=1 tag=7",
                            Cdb_valid, Cdb_branch, Cdb_branch_taken, Cdb_rd_tag);
      end
      step();
      n_checks++;
      if (Cdb_valid !== 1'b0 || Cdb_branch !== 1'b1 || Cdb_branch_taken !== 1'b0) begin
         n_fail++; $display("FAIL branch_idle: got v=%b br=%b tk=%b want v=0 br=1 tk=0",
                            Cdb_valid, Cdb_branch, Cdb_branch_taken);
      end
   endtask

   task automatic test_reset_mid();
      set_req(0, 5'd9, 32'h0000_0055, 1'b1, 1'b1);
      step();
      n_checks++;
      if (Cdb_valid !== 1'b1 || Cdb_rd_tag !== 5'd9) begin
         n_fail++; $display("FAIL mid_pre: got v=%b tag=%0d want v=1 tag=9", Cdb_valid, Cdb_rd_tag);
      end
      set_req(0, 5'd10, 32'h0000_0066, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (Fu_grant !== 4'b0001) begin
         n_fail++; $display("FAIL mid_grant: got %b want 0001", Fu_grant);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken} !== '0 || Fu_grant !== 4'b0000) begin
         n_fail++; $display("FAIL mid_async: got v=%b tag=%0d data=%h br=%b tk=%b g=%b want all 0",
                            Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken, Fu_grant);
      end
      step();
      clear_inputs();
      reset = 1'b0;
      step();
      n_checks++;
      if (Cdb_valid !== 1'b0 || Cdb_data !== 32'h0 || Cdb_rd_tag !== 5'd0) begin
         n_fail++; $display("FAIL mid_release: got v=%b tag=%0d data=%h want v=0 tag=0 data=0",
                            Cdb_valid, Cdb_rd_tag, Cdb_data);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      clear_inputs();
      #2;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_flush();
      test_branch();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of functional-unit requesters sharing the CDB.
REQ-002 SHALL have parameter TAG_W, default 5, width of the ROB tag.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port Fu_req, input, N_REQ, per-requester result-ready request.
REQ-006 SHALL have port Fu_tag, input, N_REQ*TAG_W, per-requester ROB tag, packed with requester 0 in the LSBs.
REQ-007 SHALL have port Fu_data, input, N_REQ*32, per-requester result data, packed.
REQ-008 SHALL have port Fu_branch, input, N_REQ, result is a branch.
REQ-009 SHALL have port Fu_branch_taken, input, N_REQ, branch must be taken.
REQ-010 SHALL have port flush, input, 1, pipeline flush from the ROB.
REQ-011 SHALL have port Fu_grant, output, N_REQ, one-hot grant.
REQ-012 SHALL have port Cdb_valid, output, 1, broadcast valid.
REQ-013 SHALL have port Cdb_rd_tag, output, TAG_W, broadcast tag.
REQ-014 SHALL have port Cdb_data, output, 32, broadcast data.
REQ-015 SHALL have port Cdb_branch, output, 1, broadcast branch flag.
REQ-016 SHALL have port Cdb_branch_taken, output, 1, broadcast taken flag.

Function
REQ-017 Fu_grant SHALL be combinational from Fu_req, the priority pointer and flush; at most one bit set.
REQ-018 Requester i SHALL hold Fu_req and its payload stable until the cycle Fu_grant[i]=1; the transfer completes in that cycle.
REQ-019 The granted payload SHALL appear on the Cdb_* outputs one cycle after the grant (registered; latency 1).
REQ-020 With no grant in a cycle, Cdb_valid SHALL be 0 the next cycle; Cdb_rd_tag, Cdb_data and the branch flags SHALL hold their previous values.
REQ-021 Round-robin mode: after a grant to i, the pointer SHALL become (i+1) mod N_REQ; the search starts at the pointer and wraps past N_REQ-1 to 0.
REQ-022 With no grant, the pointer SHALL remain unchanged.
REQ-023 While flush=1, Fu_grant SHALL be 0 and Cdb_valid SHALL be 0 the next cycle.
REQ-024 A flush SHALL set the pointer to 0; a broadcast already registered in the flush cycle is still presented.
REQ-025 With Fu_req all zero, Fu_grant SHALL be 0 (no spurious grant).
REQ-026 Cdb_branch_taken SHALL only be 1 when Cdb_branch=1 and Cdb_valid=1.

Reset
REQ-027 Reset SHALL clear Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken and the pointer to 0 immediately, independent of clock.
REQ-028 Fu_grant SHALL be 0 while reset=1.
REQ-029 Reset asserted mid-transfer SHALL drop the pending broadcast; the requester re-requests after reset.

Configuration
REQ-030 With macro CDB_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-021/022.
REQ-031 Without CDB_ARB_RR_EN, arbitration SHALL be fixed priority, lowest index highest, and the pointer register SHALL be absent.

Structure
REQ-032 A shared package SHALL hold the CDB payload struct (tag, data, branch, branch_taken), TAG_W and the N_REQ default.
REQ-033 One sub-module, rr_pick, SHALL implement the combinational one-hot rotate-and-select from request vector and pointer.

Verification
REQ-034 Single request: Fu_req=0001, tag 3, data 0x0000_00AA -> Fu_grant=0001 same cycle; next cycle Cdb_valid=1, Cdb_rd_tag=3, Cdb_data=0xAA.
REQ-035 Round-robin: Fu_req=1111 held 5 cycles from reset -> grants 0001,0010,0100,1000,0001 (RR build); 0001 every cycle (fixed build).
REQ-036 Wrap: pointer=3, Fu_req=1001 -> grant 1000, then 0001.
REQ-037 Flush: Fu_req=0110 with flush=1 -> Fu_grant=0, next Cdb_valid=0; the cycle after flush drops, grant=0010 (pointer 0).
REQ-038 Branch: requester 2 with branch=1, taken=1, tag 7 -> next cycle Cdb_branch=1, Cdb_branch_taken=1, Cdb_rd_tag=7.
REQ-039 Reset mid-operation: assert reset between grant and broadcast -> all Cdb_* 0 immediately; no broadcast appears after release.
